store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  FIFO of committed stores between the memory stage and the data-memory write port.
//  Accepts one store per cycle from the memory stage and aligns byte lanes from addr[1:0].
//  Forwards whole-word data to younger loads and drains in program order over a valid/ready write port.
//  Decouples store commit from data-cache write latency.
// PARAMETERS
//  DEPTH  4  entry count; power of two, >=2; PTR_W=$clog2(DEPTH) is a derived localparam
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   asynchronous reset, active-low (0 = reset)
//  capture_store     in   1   enqueue request from memory stage
//  store_addr        in   32  store byte address
//  store_data        in   32  store data, low-lane aligned (SB:[7:0], SH:[15:0])
//  store_byte_en     in   4   low-lane byte enables (0001/0011/1111; 0000 = misaligned)
//  sb_full           out  1   no free entry; memory stage must stall and hold its request
//  load_request      in   1   load in memory stage this cycle
//  load_addr         in   32  load byte address
//  forward_valid     out  1   forward_data is valid for load_addr's word
//  forward_data      out  32  youngest matching full-word entry data
//  forward_stall     out  1   partial-word match; load must wait
//  flush             in   1   level; drain all entries (fence/ecall)
//  flush_done        out  1   flush high and buffer empty
//  misaligned_store  out  1   1-cycle pulse: store dropped, byte_en==0000
//  mem_wr_valid      out  1   head entry write request
//  mem_wr_addr       out  32  word address {addr[31:2],2'b00}
//  mem_wr_data       out  32  lane-aligned data
//  mem_wr_byte_en    out  4   lane-aligned enables
//  mem_wr_ready      in   1   write accepted when valid&&ready
//  sb_empty          out  1   no valid entries
// BEHAVIOUR
//  Reset: all entries invalid, head=tail=count=0; sb_empty=1.
//   All other outputs 0 (mem_wr_*, forward_*, sb_full, flush_done, misaligned_store).
//  Alignment at enqueue:
//   be_al = store_byte_en << addr[1:0]; data_al = store_data << (8*addr[1:0]).
//   Shifts are truncated to 4/32 bits; store_byte_en==0000 -> not enqueued; misaligned_store pulses next cycle.
//  Enqueue: on capture_store && !sb_full && be!=0, write tail; tail<=tail+1 (wraps mod DEPTH).
//   capture_store while sb_full: ignored; upstream holds the request.
//  sb_full = (count==DEPTH); a dequeue in the same cycle does NOT free a slot for that cycle's enqueue.
//  Drain FSM: IDLE -> WRITE when count!=0; WRITE presents head registered (mem_wr_valid=1).
//   mem_wr_* stay stable until mem_wr_ready; on handshake head<=head+1, count-1.
//   Next state: WRITE if count>1, else IDLE.
//   One write per handshake; 1-cycle min latency enqueue -> mem_wr_valid.
//   Enqueue and dequeue in the same cycle: count unchanged.
//  Forwarding (combinational, same cycle as load_request):
//   Compare load_addr[31:2] against all valid entries, including the head in WRITE.
//   Youngest match with be_al==1111 -> forward_valid=1, forward_data=entry data.
//   Youngest match with partial be -> forward_stall=1, forward_valid=0.
//   No match or !load_request -> both 0.
//  flush: drain proceeds normally; flush_done=flush&&sb_empty; enqueues still accepted (upstream stalls).
//  Reset mid-drain: the in-flight write is abandoned; the memory side must tolerate the dropped request.
// CONFIGURATION
//  STORE_BUFFER_COALESCE_EN defined:
//   A store whose word address matches the tail-1 entry merges into it (bytes OR'd, new data wins per lane).
//   Merge happens only if that entry is not the head currently presented in WRITE.
//   A merge needs no free slot and is accepted even when sb_full.
//  Undefined: every store takes a new entry; no merge logic is synthesized.
// TESTING
//  SW 0x100=0xDEADBEEF, mem_wr_ready=1 -> mem_wr_valid next cycle, addr 0x100, be 1111, data DEADBEEF.
//  SB 0x103=0xAA -> mem_wr_byte_en 1000, mem_wr_data 0xAA000000; SH 0x101 -> misaligned_store, nothing written.
//  ready=0; 4 SW fill buffer -> sb_full=1; 5th capture ignored.
//   Raise ready -> 4 in-order writes, then sb_empty=1.
//  SW 0x200=1 then SW 0x200=2, LW 0x200 -> forward_valid=1, data=2.
//   After SB 0x204, LW 0x204 -> forward_stall=1.
//  flush=1 with 3 entries, ready toggling -> flush_done rises only after 3rd handshake.
//  COALESCE_EN: SB 0x300=0x11, SB 0x301=0x22 with ready=0 -> one entry, be 0011, data 0x2211.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of committed stores with byte-lane alignment, load forwarding and a valid/ready drain port.
// Define STORE_BUFFER_COALESCE_EN to merge a store into the youngest entry when both hit the same word.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_store,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    input  logic [3:0]  store_byte_en,
    output logic        sb_full,
    input  logic        load_request,
    input  logic [31:0] load_addr,
    output logic        forward_valid,
    output logic [31:0] forward_data,
    output logic        forward_stall,
    input  logic        flush,
    output logic        flush_done,
    output logic        misaligned_store,
    output logic        mem_wr_valid,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_byte_en,
    input  logic        mem_wr_ready,
    output logic        sb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW = PTR_W + 1;
    typedef enum logic {IDLE, WRITE} state_t;
    state_t state, state_nxt;
    logic [29:0] e_word [DEPTH];
    logic [31:0] e_data [DEPTH];
    logic [3:0]  e_be [DEPTH];
    logic [PTR_W-1:0] head, tail, idx;
    logic [CW-1:0] count;
    logic [3:0] be_al;
    logic [31:0] data_al, hit_data;
    logic enq, deq, hit, hit_full, unused_ok;
    assign be_al = store_byte_en << store_addr[1:0];
    assign data_al = store_data << {store_addr[1:0], 3'b000};
    assign sb_full = count == CW'(DEPTH);
    assign sb_empty = count == '0;
    assign flush_done = flush && sb_empty;
    assign deq = mem_wr_valid && mem_wr_ready;
    assign unused_ok = ^load_addr[1:0];
`ifdef STORE_BUFFER_COALESCE_EN
    logic merge;
    logic [PTR_W-1:0] last;
    logic [31:0] lane_mask;
    assign last = tail - PTR_W'(1);
    // The head being presented must stay stable, so it is never a merge target
    assign merge = capture_store && |store_byte_en && !sb_empty && e_word[last] == store_addr[31:2]
                   && !(state == WRITE && last == head);
    assign enq = capture_store && |store_byte_en && !sb_full && !merge;
    always_comb begin
        lane_mask = '0;
        for (int j = 0; j < 4; j++) lane_mask[8*j +: 8] = {8{be_al[j]}};
    end
`else
    assign enq = capture_store && |store_byte_en && !sb_full;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            count <= '0;
            misaligned_store <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                e_word[i] <= '0;
                e_data[i] <= '0;
                e_be[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            misaligned_store <= capture_store && store_byte_en == 4'b0000;
            count <= count + CW'(enq) - CW'(deq);
            if (deq) head <= head + PTR_W'(1);
            if (enq) begin
                e_word[tail] <= store_addr[31:2];
                e_data[tail] <= data_al;
                e_be[tail] <= be_al;
                tail <= tail + PTR_W'(1);
            end
`ifdef STORE_BUFFER_COALESCE_EN
            if (merge) begin
                e_be[last] <= e_be[last] | be_al;
                e_data[last] <= (e_data[last] & ~lane_mask) | (data_al & lane_mask);
            end
`endif
        end
    end
    always_comb begin
        state_nxt = state;
        mem_wr_valid = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_byte_en = '0;
        if (state == IDLE) begin
            state_nxt = sb_empty ? IDLE : WRITE;
        end else begin
            mem_wr_valid = 1'b1;
            mem_wr_addr = {e_word[head], 2'b00};
            mem_wr_data = e_data[head];
            mem_wr_byte_en = e_be[head];
            state_nxt = (!mem_wr_ready || count > CW'(1)) ? WRITE : IDLE;
        end
    end
    // Walk oldest to youngest so the last hit is the youngest matching entry
    always_comb begin
        hit = 1'b0;
        hit_full = 1'b0;
        hit_data = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CW'(i) < count && e_word[idx] == load_addr[31:2]) begin
                hit = 1'b1;
                hit_full = e_be[idx] == 4'hF;
                hit_data = e_data[idx];
            end
        end
    end
    assign forward_valid = load_request && hit && hit_full;
    assign forward_stall = load_request && hit && !hit_full;
    assign forward_data = forward_valid ? hit_data : '0;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vectors for store_buffer (DEPTH=4), with or without STORE_BUFFER_COALESCE_EN.
module tb_store_buffer;
    logic clk = 1'b0, rst = 1'b0;
    logic capture_store = 1'b0, load_request = 1'b0, flush = 1'b0, mem_wr_ready = 1'b0;
    logic [31:0] store_addr = '0, store_data = '0, load_addr = '0;
    logic [3:0] store_byte_en = '0;
    logic sb_full, forward_valid, forward_stall, flush_done, misaligned_store, mem_wr_valid, sb_empty;
    logic [31:0] forward_data, mem_wr_addr, mem_wr_data;
    logic [3:0] mem_wr_byte_en;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .capture_store(capture_store), .store_addr(store_addr),
        .store_data(store_data), .store_byte_en(store_byte_en), .sb_full(sb_full),
        .load_request(load_request), .load_addr(load_addr), .forward_valid(forward_valid),
        .forward_data(forward_data), .forward_stall(forward_stall), .flush(flush),
        .flush_done(flush_done), .misaligned_store(misaligned_store), .mem_wr_valid(mem_wr_valid),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_byte_en(mem_wr_byte_en),
        .mem_wr_ready(mem_wr_ready), .sb_empty(sb_empty)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        capture_store = 1'b1;
        store_addr = a;
        store_data = d;
        store_byte_en = be;
        tick();
        capture_store = 1'b0;
    endtask
    task automatic wait_wr();
        int n = 0;
        while (!mem_wr_valid && n < 10) begin
            tick();
            n++;
        end
        check("wr_valid", mem_wr_valid, 1);
    endtask
    task automatic drain();
        int n = 0;
        mem_wr_ready = 1'b1;
        while (!sb_empty && n < 20) begin
            tick();
            n++;
        end
        check("drained", sb_empty, 1);
        mem_wr_ready = 1'b0;
    endtask
    initial begin
        int hs;
        repeat (3) tick();
        check("rst_empty", sb_empty, 1);
        check("rst_full", sb_full, 0);
        check("rst_wr_valid", mem_wr_valid, 0);
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_misaligned", misaligned_store, 0);
        check("rst_fwd", {forward_valid, forward_stall}, 0);
        rst = 1'b1;
        tick();
        // SW 0x100 drains straight out
        mem_wr_ready = 1'b1;
        push(32'h100, 32'hDEADBEEF, 4'b1111);
        wait_wr();
        check("sw_addr", mem_wr_addr, 32'h100);
        check("sw_be", mem_wr_byte_en, 4'b1111);
        check("sw_data", mem_wr_data, 32'hDEADBEEF);
        tick();
        check("sw_empty", sb_empty, 1);
        check("sw_idle", mem_wr_valid, 0);
        // SB at lane 3, then a misaligned SH that must be dropped
        push(32'h103, 32'hAA, 4'b0001);
        wait_wr();
        check("sb_addr", mem_wr_addr, 32'h100);
        check("sb_be", mem_wr_byte_en, 4'b1000);
        check("sb_data", mem_wr_data, 32'hAA000000);
        tick();
        push(32'h101, 32'h1234, 4'b0000);
        check("mis_pulse", misaligned_store, 1);
        check("mis_empty", sb_empty, 1);
        tick();
        check("mis_pulse_end", misaligned_store, 0);
        check("mis_no_write", mem_wr_valid, 0);
        // Fill to full with the port stalled
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h400 + 32'(4 * i), 32'h10 + 32'(i), 4'b1111);
            check("fill_full", sb_full, i == 3);
        end
        push(32'h500, 32'hBAD, 4'b1111);
        check("full_hold", sb_full, 1);
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fifo_valid", mem_wr_valid, 1);
            check("fifo_addr", mem_wr_addr, 32'h400 + 32'(4 * i));
            check("fifo_data", mem_wr_data, 32'h10 + 32'(i));
            tick();
        end
        check("fifo_empty", sb_empty, 1);
        check("fifo_no_fifth", mem_wr_valid, 0);
        mem_wr_ready = 1'b0;
        // Forwarding
        push(32'h200, 32'h1, 4'b1111);
        push(32'h200, 32'h2, 4'b1111);
        load_request = 1'b1;
        load_addr = 32'h202;
        #1;
        check("fwd_valid", forward_valid, 1);
        check("fwd_data", forward_data, 32'h2);
        check("fwd_nostall", forward_stall, 0);
        load_request = 1'b0;
        push(32'h204, 32'h55, 4'b0001);
        load_request = 1'b1;
        load_addr = 32'h204;
        #1;
        check("fwd_stall", forward_stall, 1);
        check("fwd_stall_novalid", forward_valid, 0);
        load_addr = 32'h208;
        #1;
        check("fwd_miss", {forward_valid, forward_stall}, 0);
        load_addr = 32'h200;
        load_request = 1'b0;
        #1;
        check("fwd_noreq", {forward_valid, forward_stall}, 0);
        drain();
        // Flush with 3 entries and a toggling ready
        push(32'h600, 32'h6, 4'b1111);
        push(32'h604, 32'h7, 4'b1111);
        push(32'h608, 32'h8, 4'b1111);
        flush = 1'b1;
        #1;
        check("flush_busy", flush_done, 0);
        hs = 0;
        for (int c = 0; c < 12; c++) begin
            mem_wr_ready = (c % 2 == 1);
            #1;
            check("flush_done", flush_done, hs == 3);
            if (mem_wr_valid && mem_wr_ready) hs++;
            tick();
        end
        check("flush_hs", hs, 3);
        flush = 1'b0;
        mem_wr_ready = 1'b0;
        #1;
        check("flush_drop", flush_done, 0);
        // Two byte stores to one word
        push(32'h300, 32'h11, 4'b0001);
        push(32'h301, 32'h22, 4'b0001);
        mem_wr_ready = 1'b1;
        wait_wr();
`ifdef STORE_BUFFER_COALESCE_EN
        check("merge_be", mem_wr_byte_en, 4'b0011);
        check("merge_data", mem_wr_data, 32'h2211);
        tick();
`else
        check("nomerge_be0", mem_wr_byte_en, 4'b0001);
        check("nomerge_data0", mem_wr_data, 32'h11);
        tick();
        check("nomerge_valid1", mem_wr_valid, 1);
        check("nomerge_be1", mem_wr_byte_en, 4'b0010);
        check("nomerge_data1", mem_wr_data, 32'h2200);
        tick();
`endif
        check("byte_empty", sb_empty, 1);
        // Reset abandons an in-flight write
        mem_wr_ready = 1'b0;
        push(32'h700, 32'h7, 4'b1111);
        wait_wr();
        rst = 1'b0;
        #1;
        check("rst_mid_valid", mem_wr_valid, 0);
        check("rst_mid_empty", sb_empty, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_idle", mem_wr_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
